// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: FSM states, the packed
// command layout and a helper that builds a packed command from its fields.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  // Packed command is {control, sel, op1, op2}
  localparam int CMD_W    = 13;
  localparam int OP2_LSB  = 0;
  localparam int OP1_LSB  = 4;
  localparam int SEL_LSB  = 8;
  localparam int CTRL_BIT = 12;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic       control,
                                                 input logic [3:0] sel,
                                                 input logic [3:0] op1,
                                                 input logic [3:0] op2);
    return {control, sel, op1, op2};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered storage and pointers. Pushes into a full
// queue and pops from an empty queue are ignored; a simultaneous push and pop
// leaves the level unchanged.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued ALU commands to the shared ALU one at a time, holds the ALU
// inputs for SETTLE_CYCLES, captures the result and hands it to the LCD path
// over a req/ack handshake. A small FIFO absorbs bursts of command entry.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_control,
  input  logic [3:0]                   cmd_sel,
  input  logic [3:0]                   cmd_op1,
  input  logic [3:0]                   cmd_op2,
  output logic                         alu_control,
  output logic [3:0]                   alu_sel,
  output logic [3:0]                   alu_op1,
  output logic [3:0]                   alu_op2,
  input  logic [7:0]                   alu_result,
  output logic [7:0]                   lcd_data,
  output logic                         lcd_req,
  input  logic                         lcd_ack,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [7:0]                   result_count,
  output logic                         busy
);

  import alu_pkg::*;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    settle_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic [CMD_W-1:0] fifo_din;
  logic [CMD_W-1:0] fifo_dout;
  logic             pop;
  logic             capture;
  logic             retire;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_din  = pack_cmd(cmd_control, cmd_sel, cmd_op1, cmd_op2);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle actions: pop in IDLE, capture after settling,
  // retire on acknowledge; lcd_ack has no effect outside SHOW
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (settle_cnt == SETTLE_LAST) begin
          capture   = 1'b1;
          state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (lcd_ack) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU input registers, settle counter, LCD output registers and result count
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_control  <= 1'b0;
      alu_sel      <= '0;
      alu_op1      <= '0;
      alu_op2      <= '0;
      settle_cnt   <= '0;
      lcd_data     <= '0;
      lcd_req      <= 1'b0;
      result_count <= '0;
    end else begin
      if (pop) begin
        alu_control <= fifo_dout[CTRL_BIT];
        alu_sel     <= fifo_dout[SEL_LSB +: 4];
        alu_op1     <= fifo_dout[OP1_LSB +: 4];
        alu_op2     <= fifo_dout[OP2_LSB +: 4];
        settle_cnt  <= '0;
      end else if (state == ST_EXEC) begin
        settle_cnt  <= settle_cnt + 1'b1;
      end
      if (capture) begin
        lcd_data <= alu_result;
        lcd_req  <= 1'b1;
      end
      if (retire) begin
        lcd_req      <= 1'b0;
        result_count <= result_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer. The ALU model returns {op1, op2}.
// Accepted commands push their expected display value into a queue; a forked
// monitor pops and compares on every rising edge of lcd_req.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic       ctrl;
    logic [3:0] sel;
    logic [3:0] op1;
    logic [3:0] op2;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_control;
  logic [3:0] cmd_sel, cmd_op1, cmd_op2;
  logic       alu_control;
  logic [3:0] alu_sel, alu_op1, alu_op2;
  logic [7:0] alu_result, lcd_data, result_count;
  logic       lcd_req, lcd_ack, busy;
  logic [2:0] fifo_level;

  logic       cmd_valid_3, cmd_ready_3, cmd_control_3;
  logic [3:0] cmd_sel_3, cmd_op1_3, cmd_op2_3;
  logic       alu_control_3;
  logic [3:0] alu_sel_3, alu_op1_3, alu_op2_3;
  logic [7:0] alu_result_3, lcd_data_3, result_count_3;
  logic       lcd_req_3, lcd_ack_3, busy_3;
  logic [2:0] fifo_level_3;

  int   n_checks = 0;
  int   n_fails  = 0;
  cmd_t exp_q[$];

  always #5 clk = ~clk;

  assign alu_result   = {alu_op1, alu_op2};
  assign alu_result_3 = {alu_op1_3, alu_op2_3};

  alu_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_control(cmd_control), .cmd_sel(cmd_sel), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .alu_control(alu_control), .alu_sel(alu_sel), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .lcd_data(lcd_data), .lcd_req(lcd_req), .lcd_ack(lcd_ack),
    .fifo_level(fifo_level), .result_count(result_count), .busy(busy)
  );

  alu_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
    .cmd_control(cmd_control_3), .cmd_sel(cmd_sel_3), .cmd_op1(cmd_op1_3), .cmd_op2(cmd_op2_3),
    .alu_control(alu_control_3), .alu_sel(alu_sel_3), .alu_op1(alu_op1_3), .alu_op2(alu_op2_3),
    .alu_result(alu_result_3), .lcd_data(lcd_data_3), .lcd_req(lcd_req_3), .lcd_ack(lcd_ack_3),
    .fifo_level(fifo_level_3), .result_count(result_count_3), .busy(busy_3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.ctrl = 1'($urandom);
    c.sel  = 4'($urandom);
    c.op1  = 4'($urandom);
    c.op2  = 4'($urandom);
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    cmd_valid   = 1'b1;
    cmd_control = c.ctrl;
    cmd_sel     = c.sel;
    cmd_op1     = c.op1;
    cmd_op2     = c.op2;
  endtask

  // Offer a command until accepted, bounded; the expected result is queued
  // in the cycle the handshake completes.
  task automatic send(input cmd_t c, input int max_wait);
    bit ok;
    int w;
    ok = 1'b0;
    w  = 0;
    drive(c);
    while (!ok && w < max_wait) begin
      if (cmd_ready) begin
        exp_q.push_back(c);
        ok = 1'b1;
      end
      step();
      w++;
    end
    cmd_valid = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int max_wait);
    int w;
    w = 0;
    while (busy && w < max_wait) begin
      step();
      w++;
    end
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic monitor();
    logic       prev_req = 1'b0;
    logic [7:0] held = 8'h00;
    cmd_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (lcd_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL spurious_lcd_req: got lcd_data 0x%0h, required no request", lcd_data);
          end else begin
            e = exp_q.pop_front();
            check("lcd_data", 32'(lcd_data), 32'({e.op1, e.op2}));
            check("alu_control", 32'(alu_control), 32'(e.ctrl));
            check("alu_sel", 32'(alu_sel), 32'(e.sel));
          end
          held = lcd_data;
        end else if (lcd_req && prev_req) begin
          check("lcd_data_hold", 32'(lcd_data), 32'(held));
        end
        prev_req = lcd_req;
      end
    end
  endtask

  initial begin
    cmd_t c;
    logic [7:0] r3;
    int seen;

    fork
      monitor();
    join_none

    // Reset with random inputs
    rst = 1'b1;
    cmd_valid_3 = 1'b0; cmd_control_3 = 1'b0; cmd_sel_3 = '0;
    cmd_op1_3 = '0; cmd_op2_3 = '0; lcd_ack_3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'($urandom); lcd_ack = 1'($urandom);
      cmd_control = 1'($urandom); cmd_sel = 4'($urandom);
      cmd_op1 = 4'($urandom); cmd_op2 = 4'($urandom);
      step();
    end
    check("rst_alu", 32'({alu_control, alu_sel, alu_op1, alu_op2}), 32'd0);
    check("rst_lcd_data", 32'(lcd_data), 32'h00);
    check("rst_lcd_req", 32'(lcd_req), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_result_count", 32'(result_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; cmd_valid = 1'b0; lcd_ack = 1'b0;
    step();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Single command: push in N
    c.ctrl = 1'b1; c.sel = 4'h2; c.op1 = 4'd3; c.op2 = 4'd5;
    drive(c);
    check("single_ready", 32'(cmd_ready), 32'd1);
    exp_q.push_back(c);
    step();                                   // N+1
    cmd_valid = 1'b0;
    check("single_level_n1", 32'(fifo_level), 32'd1);
    step();                                   // N+2
    check("single_alu_op1", 32'(alu_op1), 32'd3);
    check("single_alu_op2", 32'(alu_op2), 32'd5);
    check("single_req_n2", 32'(lcd_req), 32'd0);
    step();                                   // N+3
    check("single_req_n3", 32'(lcd_req), 32'd1);
    check("single_data_n3", 32'(lcd_data), 32'h35);
    step();                                   // N+4
    step();                                   // N+5
    lcd_ack = 1'b1;
    step();                                   // N+6
    lcd_ack = 1'b0;
    check("single_req_n6", 32'(lcd_req), 32'd0);
    check("single_count", 32'(result_count), 32'd1);

    // Backpressure: 6 back-to-back commands, display never acknowledges
    for (int i = 0; i < 6; i++) begin
      c = rand_cmd();
      drive(c);
      if (i < 5) begin
        check("bp_ready_open", 32'(cmd_ready), 32'd1);
        if (cmd_ready) exp_q.push_back(c);
        step();
      end else begin
        check("bp_ready_full", 32'(cmd_ready), 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_held_ready", 32'(cmd_ready), 32'd0);
      check("bp_level", 32'(fifo_level), 32'd4);
      check("bp_req", 32'(lcd_req), 32'd1);
    end
    lcd_ack = 1'b1;                           // ack sampled in M
    step();                                   // M+1
    lcd_ack = 1'b0;
    check("bp_req_dropped", 32'(lcd_req), 32'd0);
    check("bp_ready_m1", 32'(cmd_ready), 32'd0);
    step();                                   // M+2
    check("bp_ready_m2", 32'(cmd_ready), 32'd1);
    if (cmd_ready) exp_q.push_back(c);
    step();
    cmd_valid = 1'b0;
    lcd_ack = 1'b1;
    wait_idle(200);
    lcd_ack = 1'b0;
    check("bp_count", 32'(result_count), 32'd7);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Continuous ack after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    lcd_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c = rand_cmd();
      c.op1 = 4'(i);
      c.op2 = 4'(15 - i);
      send(c, 50);
    end
    wait_idle(200);
    check("cont_count", 32'(result_count), 32'd10);
    check("cont_queue_empty", 32'(exp_q.size()), 32'd0);
    lcd_ack = 1'b0;

    // Reset while showing a result with 3 commands queued
    for (int i = 0; i < 4; i++) send(rand_cmd(), 20);
    seen = 0;
    while (!(lcd_req && fifo_level == 3) && seen < 50) begin
      step();
      seen++;
    end
    check("show_reached", 32'(lcd_req && fifo_level == 3), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("rst_show_req", 32'(lcd_req), 32'd0);
    check("rst_show_level", 32'(fifo_level), 32'd0);
    check("rst_show_count", 32'(result_count), 32'd0);
    check("rst_show_busy", 32'(busy), 32'd0);
    seen = 0;
    lcd_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (lcd_req) seen++;
    end
    lcd_ack = 1'b0;
    check("rst_show_no_req", 32'(seen), 32'd0);

    // Settle parameter on the SETTLE_CYCLES=3 instance: push in N
    cmd_valid_3 = 1'b1; cmd_control_3 = 1'b0; cmd_sel_3 = 4'h9;
    cmd_op1_3 = 4'hA; cmd_op2_3 = 4'h6;
    check("settle_ready", 32'(cmd_ready_3), 32'd1);
    step();                                   // N+1
    cmd_valid_3 = 1'b0;
    step();                                   // N+2
    check("settle_alu_op1", 32'(alu_op1_3), 32'hA);
    check("settle_req_n2", 32'(lcd_req_3), 32'd0);
    step();                                   // N+3
    check("settle_req_n3", 32'(lcd_req_3), 32'd0);
    step();                                   // N+4
    check("settle_req_n4", 32'(lcd_req_3), 32'd0);
    r3 = alu_result_3;
    step();                                   // N+5
    check("settle_req_n5", 32'(lcd_req_3), 32'd1);
    check("settle_data_sample", 32'(lcd_data_3), 32'(r3));
    check("settle_data_value", 32'(lcd_data_3), 32'hA6);
    lcd_ack_3 = 1'b1;
    step();
    lcd_ack_3 = 1'b0;
    check("settle_req_drop", 32'(lcd_req_3), 32'd0);
    check("settle_count", 32'(result_count_3), 32'd1);

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequences queued ALU commands (mode, select, two 4-bit operands) onto the shared 4-bit ALU datapath, one at a time.
- Captures each 8-bit result and hands it to the LCD display path over a req/ack handshake.
- Sits between the command source (switch/UART front end) and the ALU plus LCD display pair.
- Decouples bursty command entry from slow LCD refresh with a small command FIFO.

Parameters:
FIFO_DEPTH, 4, command queue entries; power of two, minimum 2.
SETTLE_CYCLES, 1, cycles the ALU inputs are held before the result is captured; minimum 1.

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  queue can accept
cmd_control  input  1  0 = logic unit, 1 = arithmetic unit
cmd_sel  input  4  operation select
cmd_op1  input  4  operand 1
cmd_op2  input  4  operand 2
alu_control  output  1  to ALU
alu_sel  output  4  to ALU
alu_op1  output  4  to ALU
alu_op2  output  4  to ALU
alu_result  input  8  ALU output, combinational from alu_* signals
lcd_data  output  8  result presented to the display
lcd_req  output  1  lcd_data valid; update requested
lcd_ack  input  1  display has taken lcd_data
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries queued
result_count  output  8  completed results, wraps 255->0
busy  output  1  state != IDLE or fifo_level != 0

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous and active-high.
  - On rst, all registers clear: alu_* = 0, lcd_data = 0, lcd_req = 0, result_count = 0, FIFO empty, state = IDLE.
  - cmd_ready = 1 from the first cycle after reset.
- Command queue:
  - Push occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full. A push is refused when the queue is full, even if a pop happens in the same cycle.
  - The packed entry is {control, sel, op1, op2}, 13 bits.
  - A push and a pop in the same cycle are legal when not full; fifo_level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE:
    - If fifo_level != 0: pop the head, register it onto alu_*, clear the settle counter, go to EXEC.
    - Otherwise stay in IDLE. alu_* keep their last values.
  - EXEC:
    - Count cycles.
    - At the end of the SETTLE_CYCLES-th EXEC cycle: lcd_data <= alu_result, lcd_req <= 1, go to SHOW.
  - SHOW:
    - lcd_req and lcd_data hold stable until lcd_ack = 1 is sampled.
    - On that edge: lcd_req <= 0, result_count increments, go to IDLE.
- lcd_ack is ignored in IDLE and EXEC.
- Latency, with SETTLE_CYCLES = 1 and an empty idle queue:
  - Push accepted in cycle N.
  - fifo_level = 1 in N+1; pop at the end of N+1.
  - alu_* driven from N+2.
  - lcd_req high from N+3.
- Ack to next command:
  - Ack sampled in cycle M: lcd_req low in M+1, IDLE in M+1.
  - Next pop at the end of M+1; next alu_* values in M+2.
- Commands complete strictly in FIFO order; there is no reordering or overlap.
- Reset mid-operation (any state):
  - Next cycle: IDLE, queue flushed, lcd_req = 0.
  - The pending result is discarded and result_count = 0.

Decomposition:
- Shared package (alu_pkg) holds:
  - State encodings IDLE/EXEC/SHOW.
  - CMD_W = 13.
  - Field offsets for control/sel/op1/op2 inside the packed command.
- One sub-module: cmd_fifo.
  - Synchronous, registered, parameterised by depth and width.
  - Ports: push/pop/full/empty/level.
- The sequencer holds the FSM, settle counter, output registers and result_count.

Test Plan:
- Reset:
  - Assert rst for 2 cycles with random inputs → alu_* = 0, lcd_data = 0x00, lcd_req = 0, fifo_level = 0, result_count = 0, busy = 0.
  - cmd_ready = 1 on the first cycle after rst is released.
- Single command:
  - The bench ALU model returns {op1, op2}. Push control=1, sel=4'h2, op1=3, op2=5 in cycle N.
  - Required: alu_op1 = 3 and alu_op2 = 5 at N+2; lcd_req = 1 with lcd_data = 0x35 at N+3.
  - Ack at N+5 → lcd_req = 0 at N+6, result_count = 1.
- Backpressure:
  - Hold lcd_ack = 0 and push 6 back-to-back commands.
  - Required: first command enters SHOW; cmd_ready drops after 4 more are queued (fifo_level = 4); the 6th is held.
  - A single ack frees a slot 2 cycles later and the 6th is accepted.
- Continuous ack:
  - Tie lcd_ack = 1 and push 10 distinct commands.
  - Required: lcd_data sequence matches push order; result_count = 10; busy = 0 at the end.
  - No lcd_req pulse is shorter than 1 cycle.
- Reset in SHOW:
  - Assert rst while lcd_req = 1 with 3 commands queued.
  - Required: next cycle lcd_req = 0, fifo_level = 0, result_count = 0; no further lcd_req.
- Settle parameter:
  - SETTLE_CYCLES = 3, push in cycle N.
  - Required: lcd_req first high at N+5; lcd_data equals alu_result sampled at the end of N+4.
